// File: rtl/rv32v_types_pkg.sv
// Shared types for the rv32v micro-op sequencer: vtype encodings, sequencer state
// and the micro-op record handed to the execute stage.
package rv32v_types_pkg;

  typedef enum logic [1:0] {
    SEW8    = 2'd0,
    SEW16   = 2'd1,
    SEW32   = 2'd2,
    SEW_ILL = 2'd3
  } sew_t;

  // Only integer group sizes exist; encodings 4..7 would be fractional LMUL.
  typedef enum logic [2:0] {
    LMUL1 = 3'd0,
    LMUL2 = 3'd1,
    LMUL4 = 3'd2,
    LMUL8 = 3'd3
  } lmul_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } seq_state_t;

  // Record widths match the default VLENB=16 / LANES=2 configuration.
  localparam int UOP_IDX_W = 8;
  localparam int UOP_LANES = 2;

  typedef struct packed {
    logic [31:0]          instr;
    logic [4:0]           vd;
    logic [4:0]           vs1;
    logic [4:0]           vs2;
    logic [UOP_IDX_W-1:0] elem_idx;
    logic [UOP_LANES-1:0] lane_mask;
    logic                 first;
    logic                 last;
  } uop_t;

endpackage

// File: rtl/rv32v_uop_sequencer_if.sv
// Instruction-in / micro-op-out valid/ready bundle between decode, sequencer and execute.
interface rv32v_uop_sequencer_if #(
  parameter int LANES = 2,
  parameter int VLW   = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [VLW-1:0]   in_vl;
  logic [VLW-1:0]   in_vstart;
  logic [1:0]       in_sew;
  logic [2:0]       in_lmul;
  logic             in_vill;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [4:0]       out_vd;
  logic [4:0]       out_vs1;
  logic [4:0]       out_vs2;
  logic [VLW-1:0]   out_elem_idx;
  logic [LANES-1:0] out_lane_mask;
  logic             out_first;
  logic             out_last;

  modport master (
    output in_valid, in_instr, in_vl, in_vstart, in_sew, in_lmul, in_vill, out_ready,
    input  in_ready, out_valid, out_instr, out_vd, out_vs1, out_vs2,
           out_elem_idx, out_lane_mask, out_first, out_last
  );

  modport slave (
    input  in_valid, in_instr, in_vl, in_vstart, in_sew, in_lmul, in_vill, out_ready,
    output in_ready, out_valid, out_instr, out_vd, out_vs1, out_vs2,
           out_elem_idx, out_lane_mask, out_first, out_last
  );
endinterface

// File: rtl/rv32v_beat_calc.sv
// Per-beat geometry: where the current beat ends, which lanes are live, which
// register of the group it touches and whether it is the final beat.
module rv32v_beat_calc #(
  parameter int VLENB = 16,
  parameter int LANES = 2,
  parameter int VLW   = $clog2(VLENB*8)+1
) (
  input  logic [VLW-1:0]   idx,
  input  logic [VLW-1:0]   eff_vl,
  input  logic [1:0]       sew,
  output logic [VLW-1:0]   boundary,
  output logic [LANES-1:0] lane_mask,
  output logic [2:0]       grp_off,
  output logic             last
);
  localparam int LOG_VLENB = $clog2(VLENB);

  logic [4:0]   epr_shift;
  logic [VLW:0] reg_num;
  logic [VLW:0] reg_end;
  logic [VLW:0] lane_end;

  // Elements per register is a power of two, so idx/epr is a shift; the beat is
  // clipped to whichever comes first: lane count, vector length, register end.
  always_comb begin
    epr_shift = 5'(LOG_VLENB) - {3'b000, sew};
    reg_num   = {1'b0, idx} >> epr_shift;
    reg_end   = (reg_num + 1'b1) << epr_shift;
    lane_end  = {1'b0, idx} + (VLW+1)'(LANES);
    boundary  = eff_vl;
    if (lane_end < {1'b0, boundary}) boundary = lane_end[VLW-1:0];
    if (reg_end < {1'b0, boundary}) boundary = reg_end[VLW-1:0];
    grp_off   = reg_num[2:0];
    last      = (boundary == eff_vl);
    lane_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_mask[i] = ({1'b0, idx} + (VLW+1)'(i)) < {1'b0, boundary};
    end
  end
endmodule

// File: rtl/rv32v_uop_sequencer.sv
// Splits one decoded vector instruction into LANES-wide micro-op beats walking
// element indices from vstart to the clamped vector length.
module rv32v_uop_sequencer
  import rv32v_types_pkg::*;
#(
  parameter int VLENB = 16,
  parameter int LANES = 2,
  parameter int VLW   = $clog2(VLENB*8)+1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  flush,
  rv32v_uop_sequencer_if.slave  bus,
  output logic                  done,
  output logic                  illegal
);
  seq_state_t       state, state_n;
  logic [31:0]      instr_q;
  sew_t             sew_q;
  logic [VLW-1:0]   eff_vl_q, idx_q, idx_n;
  logic             first_q, first_n;
  logic             empty_q, empty_n, illegal_n, load;
  logic [VLW:0]     vlmax;
  logic [VLW-1:0]   acc_eff_vl;
  logic             bad_vtype;
  logic [VLW-1:0]   boundary;
  logic [LANES-1:0] lane_mask;
  logic [2:0]       grp_off;
  logic             beat_last;
  logic             issuing, xfer;

  rv32v_beat_calc #(.VLENB(VLENB), .LANES(LANES), .VLW(VLW)) u_beat (
    .idx       (idx_q),
    .eff_vl    (eff_vl_q),
    .sew       (sew_q),
    .boundary  (boundary),
    .lane_mask (lane_mask),
    .grp_off   (grp_off),
    .last      (beat_last)
  );

  always_comb begin
    vlmax      = ((VLW+1)'(VLENB) << bus.in_lmul[1:0]) >> bus.in_sew;
    acc_eff_vl = ({1'b0, bus.in_vl} < vlmax) ? bus.in_vl : vlmax[VLW-1:0];
    bad_vtype  = (bus.in_sew == 2'd3) | bus.in_lmul[2] | bus.in_vill;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      instr_q  <= '0;
      sew_q    <= SEW8;
      eff_vl_q <= '0;
      idx_q    <= '0;
      first_q  <= 1'b0;
      empty_q  <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state   <= state_n;
      idx_q   <= idx_n;
      first_q <= first_n;
      empty_q <= empty_n;
      illegal <= illegal_n;
      if (load) begin
        instr_q  <= bus.in_instr;
        sew_q    <= sew_t'(bus.in_sew);
        eff_vl_q <= acc_eff_vl;
      end
    end
  end

  // Flush outranks everything: it rejects an offered instruction and drops an
  // in-flight beat as if it had never been transferred.
  always_comb begin
    state_n   = state;
    idx_n     = idx_q;
    first_n   = first_q;
    empty_n   = 1'b0;
    illegal_n = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && !flush) begin
          if (bad_vtype) begin
            illegal_n = 1'b1;
          end else if (bus.in_vstart >= acc_eff_vl) begin
            empty_n = 1'b1;
          end else begin
            state_n = ISSUE;
            idx_n   = bus.in_vstart;
            first_n = 1'b1;
            load    = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (flush) begin
          state_n = IDLE;
        end else if (bus.out_ready) begin
          idx_n   = boundary;
          first_n = 1'b0;
          if (beat_last) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    issuing           = (state == ISSUE);
    xfer              = issuing & bus.out_ready & ~flush;
    bus.in_ready      = (state == IDLE);
    bus.out_valid     = issuing;
    bus.out_instr     = issuing ? instr_q : '0;
    bus.out_vd        = issuing ? instr_q[11:7]  + {2'b00, grp_off} : '0;
    bus.out_vs1       = issuing ? instr_q[19:15] + {2'b00, grp_off} : '0;
    bus.out_vs2       = issuing ? instr_q[24:20] + {2'b00, grp_off} : '0;
    bus.out_elem_idx  = issuing ? idx_q : '0;
    bus.out_lane_mask = issuing ? lane_mask : '0;
    bus.out_first     = issuing & first_q;
    bus.out_last      = issuing & beat_last;
    done              = empty_q | (xfer & beat_last);
  end
endmodule

// File: tb/tb_rv32v_uop_sequencer.sv
// Directed bench for rv32v_uop_sequencer at VLENB=16, LANES=2 with hand-computed beats.
module tb_rv32v_uop_sequencer;
  localparam int VLENB = 16;
  localparam int LANES = 2;
  localparam int VLW   = 8;

  logic CLK;
  logic RST;
  logic flush;
  logic done;
  logic illegal;
  int   checks = 0;
  int   errors = 0;

  rv32v_uop_sequencer_if #(.LANES(LANES), .VLW(VLW)) bus ();

  rv32v_uop_sequencer #(.VLENB(VLENB), .LANES(LANES), .VLW(VLW)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .flush   (flush),
    .bus     (bus),
    .done    (done),
    .illegal (illegal)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mkInstr(input logic [4:0] vd, input logic [4:0] vs1,
                                          input logic [4:0] vs2);
    return {7'b0000000, vs2, vs1, 3'b000, vd, 7'h57};
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Offer one instruction for a single clock edge, then withdraw it.
  task automatic applyStimulus(input logic [31:0] instr, input logic [7:0] vl,
                               input logic [7:0] vstart, input logic [1:0] sew,
                               input logic [2:0] lmul, input logic vill);
    bus.in_instr  = instr;
    bus.in_vl     = vl;
    bus.in_vstart = vstart;
    bus.in_sew    = sew;
    bus.in_lmul   = lmul;
    bus.in_vill   = vill;
    bus.in_valid  = 1'b1;
    step();
    bus.in_valid  = 1'b0;
  endtask

  task automatic checkBeat(input string tag, input logic [7:0] idx, input logic [1:0] mask,
                           input logic [4:0] vd, input logic first, input logic last,
                           input logic dn);
    checkOutput({tag, " valid"}, 32'(bus.out_valid), 32'd1);
    checkOutput({tag, " idx"},   32'(bus.out_elem_idx), 32'(idx));
    checkOutput({tag, " mask"},  32'(bus.out_lane_mask), 32'(mask));
    checkOutput({tag, " vd"},    32'(bus.out_vd), 32'(vd));
    checkOutput({tag, " first"}, 32'(bus.out_first), 32'(first));
    checkOutput({tag, " last"},  32'(bus.out_last), 32'(last));
    checkOutput({tag, " done"},  32'(done), 32'(dn));
  endtask

  task automatic checkIdle(input string tag, input logic dn, input logic ill);
    checkOutput({tag, " valid"},   32'(bus.out_valid), 32'd0);
    checkOutput({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
    checkOutput({tag, " done"},    32'(done), 32'(dn));
    checkOutput({tag, " illegal"}, 32'(illegal), 32'(ill));
  endtask

  initial begin
    RST           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_vl     = '0;
    bus.in_vstart = '0;
    bus.in_sew    = '0;
    bus.in_lmul   = '0;
    bus.in_vill   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;

    $display("[TB] reset state");
    checkIdle("reset", 1'b0, 1'b0);
    checkOutput("reset first", 32'(bus.out_first), 32'd0);
    checkOutput("reset last",  32'(bus.out_last), 32'd0);
    checkOutput("reset idx",   32'(bus.out_elem_idx), 32'd0);
    checkOutput("reset vd",    32'(bus.out_vd), 32'd0);
    checkOutput("reset mask",  32'(bus.out_lane_mask), 32'd0);
    checkOutput("reset instr", bus.out_instr, 32'd0);

    $display("[TB] SEW32 LMUL1 vl=4");
    applyStimulus(mkInstr(5'd3, 5'd1, 5'd2), 8'd4, 8'd0, 2'd2, 3'd0, 1'b0);
    checkBeat("t1b0", 8'd0, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0);
    checkOutput("t1b0 in_ready", 32'(bus.in_ready), 32'd0);
    checkOutput("t1b0 vs1", 32'(bus.out_vs1), 32'd1);
    checkOutput("t1b0 vs2", 32'(bus.out_vs2), 32'd2);
    checkOutput("t1b0 instr", bus.out_instr, mkInstr(5'd3, 5'd1, 5'd2));
    step();
    checkBeat("t1b1", 8'd2, 2'b11, 5'd3, 1'b0, 1'b1, 1'b1);
    step();
    checkIdle("t1end", 1'b0, 1'b0);

    $display("[TB] SEW32 LMUL2 vl=7 group walk");
    applyStimulus(mkInstr(5'd30, 5'd29, 5'd31), 8'd7, 8'd0, 2'd2, 3'd1, 1'b0);
    checkBeat("t2b0", 8'd0, 2'b11, 5'd30, 1'b1, 1'b0, 1'b0);
    checkOutput("t2b0 vs2", 32'(bus.out_vs2), 32'd31);
    step();
    checkBeat("t2b1", 8'd2, 2'b11, 5'd30, 1'b0, 1'b0, 1'b0);
    step();
    checkBeat("t2b2", 8'd4, 2'b11, 5'd31, 1'b0, 1'b0, 1'b0);
    checkOutput("t2b2 vs1", 32'(bus.out_vs1), 32'd30);
    checkOutput("t2b2 vs2 wrap", 32'(bus.out_vs2), 32'd0);
    step();
    checkBeat("t2b3", 8'd6, 2'b01, 5'd31, 1'b0, 1'b1, 1'b1);
    step();
    checkIdle("t2end", 1'b0, 1'b0);

    $display("[TB] vstart=3 single beat");
    applyStimulus(mkInstr(5'd8, 5'd0, 5'd0), 8'd4, 8'd3, 2'd2, 3'd0, 1'b0);
    checkBeat("t3b0", 8'd3, 2'b01, 5'd8, 1'b1, 1'b1, 1'b1);
    step();
    checkIdle("t3end", 1'b0, 1'b0);

    $display("[TB] empty and illegal instructions");
    applyStimulus(mkInstr(5'd1, 5'd0, 5'd0), 8'd0, 8'd0, 2'd2, 3'd0, 1'b0);
    checkIdle("vl0", 1'b1, 1'b0);
    step();
    checkIdle("vl0 after", 1'b0, 1'b0);
    applyStimulus(mkInstr(5'd1, 5'd0, 5'd0), 8'd4, 8'd0, 2'd3, 3'd0, 1'b0);
    checkIdle("sew3", 1'b0, 1'b1);
    step();
    checkIdle("sew3 after", 1'b0, 1'b0);
    applyStimulus(mkInstr(5'd1, 5'd0, 5'd0), 8'd4, 8'd0, 2'd0, 3'd4, 1'b0);
    checkIdle("lmul4", 1'b0, 1'b1);
    step();
    applyStimulus(mkInstr(5'd1, 5'd0, 5'd0), 8'd4, 8'd0, 2'd0, 3'd0, 1'b1);
    checkIdle("vill", 1'b0, 1'b1);
    step();

    $display("[TB] SEW8 vl=40 clamped with stall");
    applyStimulus(mkInstr(5'd4, 5'd5, 5'd6), 8'd40, 8'd0, 2'd0, 3'd0, 1'b0);
    for (int b = 0; b < 8; b++) begin
      checkBeat($sformatf("t5b%0d", b), 8'(2*b), 2'b11, 5'd4, b == 0, b == 7, b == 7);
      if (b == 2) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          checkBeat($sformatf("t5stall%0d", s), 8'd4, 2'b11, 5'd4, 1'b0, 1'b0, 1'b0);
          checkOutput($sformatf("t5stall%0d vs1", s), 32'(bus.out_vs1), 32'd5);
        end
        bus.out_ready = 1'b1;
      end
      step();
    end
    checkIdle("t5end", 1'b0, 1'b0);

    $display("[TB] flush mid-instruction");
    applyStimulus(mkInstr(5'd30, 5'd29, 5'd31), 8'd7, 8'd0, 2'd2, 3'd1, 1'b0);
    checkBeat("t6b0", 8'd0, 2'b11, 5'd30, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    checkOutput("t6 flush done", 32'(done), 32'd0);
    step();
    flush = 1'b0;
    checkIdle("t6 flushed", 1'b0, 1'b0);
    flush = 1'b1;
    applyStimulus(mkInstr(5'd9, 5'd0, 5'd0), 8'd4, 8'd0, 2'd2, 3'd0, 1'b0);
    flush = 1'b0;
    checkIdle("t6 rejected", 1'b0, 1'b0);
    step();
    checkIdle("t6 rejected2", 1'b0, 1'b0);
    applyStimulus(mkInstr(5'd5, 5'd0, 5'd0), 8'd3, 8'd0, 2'd1, 3'd0, 1'b0);
    checkBeat("t6n0", 8'd0, 2'b11, 5'd5, 1'b1, 1'b0, 1'b0);
    step();
    checkBeat("t6n1", 8'd2, 2'b01, 5'd5, 1'b0, 1'b1, 1'b1);
    step();
    checkIdle("t6end", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rv32v_uop_sequencer.md
Name: rv32v_uop_sequencer

Overview:
Splits one decoded vector instruction into a stream of per-beat micro-ops for a LANES-wide execute datapath, walking element indices from vstart to vl-1 under the current SEW/LMUL. Sits between the rv32v decode stage and the execute stage, replacing single-shot issue with a parametrised lane-count and register-group sequencer. Valid/ready on both sides; stall and flush come from the hazard unit.

Parameters:
VLENB, 16, bytes per vector register (power of 2, >= 4)
LANES, 2, elements issued per beat (power of 2, <= VLENB/4)
VLW, $clog2(VLENB*8)+1, width of vl/vstart/element index

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
flush  in  1  discard current instruction (hazard unit)
in_valid  in  1  instruction offered
in_ready  out  1  sequencer can accept
in_instr  in  32  raw vector instruction word
in_vl  in  VLW  vector length
in_vstart  in  VLW  start element
in_sew  in  2  0=SEW8, 1=SEW16, 2=SEW32, 3=illegal
in_lmul  in  3  0..3 = LMUL1/2/4/8; 4..7 illegal (fractional unsupported)
in_vill  in  1  vtype illegal
out_valid  out  1  micro-op valid
out_ready  in  1  execute accepts micro-op
out_instr  out  32  captured instruction word
out_vd, out_vs1, out_vs2  out  5 each  base register + group offset, mod 32
out_elem_idx  out  VLW  element index of lane 0
out_lane_mask  out  LANES  bit i set when element out_elem_idx+i is active
out_first, out_last  out  1 each  first/last beat of instruction
done  out  1  one-cycle pulse when instruction fully issued or retired empty
illegal  out  1  one-cycle pulse on illegal sew/lmul/vill

Behaviour:
- Reset (RST high at CLK edge): state IDLE; out_valid, done, illegal, out_first, out_last = 0; all data outputs 0; in_ready = 1 the cycle after.
- FSM: IDLE, ISSUE. in_ready = 1 only in IDLE (one-cycle bubble between instructions).
- IDLE, accept (in_valid & in_ready): capture instr, vd = instr[11:7], vs1 = instr[19:15], vs2 = instr[24:20], sew, lmul.
  - sew==3, lmul>3, or in_vill: illegal pulses next cycle, stay IDLE, no micro-ops.
  - vlmax = (VLENB << lmul) >> sew; eff_vl = min(in_vl, vlmax).
  - in_vstart >= eff_vl (includes vl==0): done pulses next cycle, stay IDLE.
  - Otherwise: idx = in_vstart, go ISSUE; out_valid = 1 next cycle.
- ISSUE beat: epr = VLENB >> sew; boundary = min(idx+LANES, eff_vl, (idx/epr+1)*epr); a beat never crosses a register boundary. Lane i is active iff idx+i < boundary. Group offset = idx/epr (0..7), added to vd/vs1/vs2 with 5-bit wrap.
- out_first = 1 on the first beat only. out_last = 1 when boundary == eff_vl.
- Handshake: outputs hold stable while out_valid & !out_ready. On out_valid & out_ready: idx = boundary; if out_last, go IDLE and pulse done in the same cycle as the final transfer.
- flush: highest priority after RST. Next cycle: IDLE, out_valid = 0, no done pulse. A flush coinciding with in_valid rejects that instruction.
- Simultaneous out_ready and flush: the flush wins and the beat is treated as not transferred.

Decomposition:
- rv32v_types_pkg: add sew_t/lmul_t enums (if absent), uop_t struct {instr, vd, vs1, vs2, elem_idx, lane_mask, first, last}, and seq_state_t {IDLE, ISSUE}.
- One sub-module, rv32v_beat_calc: combinational boundary, lane_mask, group-offset and last computation from idx, eff_vl and sew. Unit-tested separately.

Test Plan (VLENB=16, LANES=2, out_ready=1 unless stated):
- SEW32, LMUL1, vl=4, vstart=0, vd=3 -> 2 beats: idx 0 mask 11 first; idx 2 mask 11 last. out_vd = 3 on both beats; done pulses with the second transfer.
- SEW32, LMUL2, vl=7, vd=30 -> 4 beats: idx 0/2/4/6; out_vd 30, 30, 31, 31; final mask 01 with last.
- SEW32, LMUL1, vl=4, vstart=3 -> single beat: idx 3, mask 01, first & last both 1.
- vl=0 -> no out_valid; done pulses 1 cycle after accept; in_ready returns to 1. Separately, sew=3 -> illegal pulse, no out_valid.
- SEW8, LMUL1, vl=40 (clamped to vlmax 16) -> 8 beats; out_ready low 3 cycles at beat 2 -> all outputs stable across the stall, then issue resumes.
- flush asserted during beat 1 of a 4-beat instruction -> out_valid 0 the next cycle, no done pulse, in_ready 1; the next instruction issues normally.
